barrel_scheduler: RTL
=====================

Name: barrel_scheduler

Overview:
Owns the barrel slot table that feeds the barrel drawing stage (`barrel` enable vector, plus `xpos`/`ypos` per slot). On each frame tick it walks the slots, advancing every active barrel along a zig-zag path: roll horizontally, drop at the wall, reverse direction. It spawns new barrels periodically into free slots and retires barrels that fall off the bottom or are killed. It sits beside the other game-logic controllers, ahead of the draw pipeline.

Parameters:
- BARRELS, 5, number of slots (1..16).
- SPAWN_PERIOD, 120, frames between spawns.
- SPAWN_X, 100, spawn x position.
- SPAWN_Y, 150, spawn y position.
- X_MIN, 32, left turn-around x.
- X_MAX, 960, right turn-around x.
- STEP, 2, horizontal pixels moved per frame.
- DROP, 96, vertical pixels dropped at each wall.
- Y_LIMIT, 700, despawn threshold on y.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start_game  in  1  game running
- animation  in  1  intro animation in progress; freezes the scheduler
- frame_tick  in  1  one-cycle pulse per frame (vblank start)
- kill  in  BARRELS  per-slot retire request, one-cycle pulse
- barrel  out  BARRELS  slot active
- xpos  out  BARRELS x 11  x position per slot
- ypos  out  BARRELS x 11  y position per slot
- busy  out  1  frame update in progress
- spawned  out  1  one-cycle pulse when a barrel is spawned

Behaviour:
- Reset:
  - `barrel`, `xpos`, `ypos`, `busy`, `spawned` = 0.
  - All direction bits = right.
  - Frame counter = SPAWN_PERIOD-1.
  - State = IDLE.
- FSM states: IDLE, WAIT, UPDATE, SPAWN.
- IDLE:
  - Outputs are held cleared.
  - Goes to WAIT when `start_game` = 1.
- Any state with `start_game` = 0: next cycle is IDLE. Slots, counter and directions are cleared, as at reset.
- WAIT:
  - A `frame_tick` with `animation` = 0 moves to UPDATE with index i = 0 and sets `busy`.
  - A `frame_tick` with `animation` = 1 is ignored; all state is held.
- UPDATE: one slot per cycle, i = 0..BARRELS-1. For an active slot:
  - Moving right: if x+STEP >= X_MAX, then x = X_MAX, y += DROP and direction flips; else x += STEP.
  - Moving left: if x <= X_MIN+STEP, then x = X_MIN, y += DROP and direction flips; else x -= STEP.
  - If the new y >= Y_LIMIT, the slot is cleared (`barrel`[i] = 0).
  - Inactive slots are untouched.
  - After i = BARRELS-1, go to SPAWN.
- SPAWN (one cycle):
  - If the frame counter = SPAWN_PERIOD-1 and a free slot exists: the lowest-index free slot gets x = SPAWN_X, y = SPAWN_Y, direction right, `barrel` = 1. `spawned` pulses and the counter resets to 0.
  - If the counter is at SPAWN_PERIOD-1 but all slots are full: the counter holds and the spawn is retried next frame.
  - Otherwise the counter increments.
  - Then return to WAIT and clear `busy`.
- First spawn: because the counter resets to SPAWN_PERIOD-1, the first tick after start spawns immediately.
- Latency: a tick is fully processed BARRELS+1 cycles after entering UPDATE. A spawned barrel is not moved in its spawn frame.
- `frame_tick` while `busy` = 1 is ignored.
- `kill`:
  - Applies in any non-IDLE state and clears `barrel`[k] on the next edge.
  - Kill beats a same-cycle UPDATE of that slot.
  - A slot killed in the SPAWN cycle is not reusable until the next frame.
- Arithmetic is 11-bit unsigned. Parameter constraints guarantee no underflow: X_MIN >= STEP and Y_LIMIT+DROP < 2048.
- All outputs are registered; positions are stable outside the update window, so the draw path sees values that change only between frames.

Decomposition:
- `donkey_pkg` holds:
  - the scheduler state enum `barrel_sched_state_t`;
  - default geometry constants (turn-around x values, DROP, Y_LIMIT, spawn point);
  - the existing CHARACTER_WIDTH and CHARACTER_HEIGHT, to clamp X_MAX.
- One natural sub-module: `barrel_slot_step`, combinational. It takes x, y and direction and returns next x, next y, next direction and a despawn flag. It is instanced once and muxed by i.

Test Plan:
- Reset, then `start_game` = 1 and one tick → after 6 cycles: `barrel` = 00001, `xpos[0]` = 100, `ypos[0]` = 150, `spawned` pulsed once.
- Next tick → `xpos[0]` = 102. After 120 ticks slot 1 spawns, giving `barrel` = 00011.
- Slot at x = 959 moving right, one tick → x = 960, y += 96, direction left. Next tick → x = 958.
- Slot at y = 630 reaching a wall → y = 726 ≥ 700, so the slot clears. The next spawn reuses that lowest free index.
- All 5 slots full at spawn time → no spawn and the counter holds. A kill of slot 2 → slot 2 spawns on the following tick.
- `animation` = 1 across 10 ticks → no change. `start_game` falling mid-UPDATE → next cycle all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/donkey_pkg.sv
// Shared game-logic types and geometry constants for the barrel scheduler.
// Geometry defaults describe the zig-zag path barrels follow down the screen.
package donkey_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_SPAWN  = 2'd3
    } barrel_sched_state_t;

    localparam int SCREEN_WIDTH     = 1024;
    localparam int CHARACTER_WIDTH  = 64;
    localparam int CHARACTER_HEIGHT = 64;

    localparam int BARREL_SPAWN_PERIOD = 120;
    localparam int BARREL_SPAWN_X      = 100;
    localparam int BARREL_SPAWN_Y      = 150;
    localparam int BARREL_X_MIN        = 32;
    localparam int BARREL_X_MAX        = 960;
    localparam int BARREL_STEP         = 2;
    localparam int BARREL_DROP         = 96;
    localparam int BARREL_Y_LIMIT      = 700;

    // Keeps the right turn-around point such that a sprite never leaves the screen.
    function automatic int clamp_x_max(input int x_max);
        return (x_max > SCREEN_WIDTH - CHARACTER_WIDTH) ? SCREEN_WIDTH - CHARACTER_WIDTH : x_max;
    endfunction

endpackage

// File: rtl/barrel_slot_step.sv
// One frame of motion for a single barrel: roll, drop and reverse at walls,
// and flag the barrel for despawn once it passes the bottom limit.
module barrel_slot_step
    import donkey_pkg::*;
#(
    parameter int X_MIN   = BARREL_X_MIN,
    parameter int X_MAX   = BARREL_X_MAX,
    parameter int STEP    = BARREL_STEP,
    parameter int DROP    = BARREL_DROP,
    parameter int Y_LIMIT = BARREL_Y_LIMIT
) (
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        dir_left,
    output logic [10:0] x_next,
    output logic [10:0] y_next,
    output logic        dir_left_next,
    output logic        despawn
);

    always_comb begin
        x_next        = x;
        y_next        = y;
        dir_left_next = dir_left;
        if (!dir_left) begin
            // Widened compare so x+STEP cannot wrap near the top of the range.
            if (({1'b0, x} + 12'(STEP)) >= 12'(X_MAX)) begin
                x_next        = 11'(X_MAX);
                y_next        = y + 11'(DROP);
                dir_left_next = 1'b1;
            end else begin
                x_next = x + 11'(STEP);
            end
        end else begin
            if ({1'b0, x} <= 12'(X_MIN + STEP)) begin
                x_next        = 11'(X_MIN);
                y_next        = y + 11'(DROP);
                dir_left_next = 1'b0;
            end else begin
                x_next = x - 11'(STEP);
            end
        end
        despawn = (y_next >= 11'(Y_LIMIT));
    end

endmodule

// File: rtl/barrel_scheduler.sv
// Barrel slot table: per frame, steps each active slot one per cycle, then
// optionally spawns a new barrel into the lowest free slot.
module barrel_scheduler
    import donkey_pkg::*;
#(
    parameter int BARRELS      = 5,
    parameter int SPAWN_PERIOD = BARREL_SPAWN_PERIOD,
    parameter int SPAWN_X      = BARREL_SPAWN_X,
    parameter int SPAWN_Y      = BARREL_SPAWN_Y,
    parameter int X_MIN        = BARREL_X_MIN,
    parameter int X_MAX        = BARREL_X_MAX,
    parameter int STEP         = BARREL_STEP,
    parameter int DROP         = BARREL_DROP,
    parameter int Y_LIMIT      = BARREL_Y_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_game,
    input  logic                     animation,
    input  logic                     frame_tick,
    input  logic [BARRELS-1:0]       kill,
    output logic [BARRELS-1:0]       barrel,
    output logic [BARRELS-1:0][10:0] xpos,
    output logic [BARRELS-1:0][10:0] ypos,
    output logic                     busy,
    output logic                     spawned
);

    localparam int X_MAX_C = clamp_x_max(X_MAX);
    localparam int CNT_W   = $clog2(SPAWN_PERIOD + 1);
    localparam int IDX_W   = (BARRELS > 1) ? $clog2(BARRELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BARRELS - 1);

    barrel_sched_state_t state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BARRELS-1:0]       dir_q, dir_d;
    logic [BARRELS-1:0]       barrel_q, barrel_d;
    logic [BARRELS-1:0][10:0] xpos_q, xpos_d;
    logic [BARRELS-1:0][10:0] ypos_q, ypos_d;
    logic                     busy_q, busy_d;
    logic                     spawned_q, spawned_d;

    logic [10:0]      step_x, step_y;
    logic             step_dir, step_despawn;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    barrel_slot_step #(
        .X_MIN  (X_MIN),
        .X_MAX  (X_MAX_C),
        .STEP   (STEP),
        .DROP   (DROP),
        .Y_LIMIT(Y_LIMIT)
    ) u_step (
        .x            (xpos_q[idx_q]),
        .y            (ypos_q[idx_q]),
        .dir_left     (dir_q[idx_q]),
        .x_next       (step_x),
        .y_next       (step_y),
        .dir_left_next(step_dir),
        .despawn      (step_despawn)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = BARRELS - 1; k >= 0; k--) begin
            if (!barrel_q[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!start_game) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WAIT;
                ST_WAIT:   if (frame_tick && !animation) state_d = ST_UPDATE;
                ST_UPDATE: if (idx_q == IDX_LAST) state_d = ST_SPAWN;
                ST_SPAWN:  state_d = ST_WAIT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        barrel_d  = barrel_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        busy_d    = busy_q;
        spawned_d = 1'b0;
        if (!start_game || state_q == ST_IDLE) begin
            idx_d    = '0;
            cnt_d    = CNT_LAST;
            dir_d    = '0;
            barrel_d = '0;
            xpos_d   = '0;
            ypos_d   = '0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (frame_tick && !animation) begin
                        idx_d  = '0;
                        busy_d = 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (barrel_q[idx_q]) begin
                        xpos_d[idx_q] = step_x;
                        ypos_d[idx_q] = step_y;
                        dir_d[idx_q]  = step_dir;
                        if (step_despawn) barrel_d[idx_q] = 1'b0;
                    end
                    idx_d = idx_q + 1'b1;
                end
                ST_SPAWN: begin
                    // A full table holds the counter so the spawn retries next frame.
                    if (cnt_q == CNT_LAST) begin
                        if (free_found) begin
                            xpos_d[free_idx]   = 11'(SPAWN_X);
                            ypos_d[free_idx]   = 11'(SPAWN_Y);
                            dir_d[free_idx]    = 1'b0;
                            barrel_d[free_idx] = 1'b1;
                            spawned_d          = 1'b1;
                            cnt_d              = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    busy_d = 1'b0;
                end
                default: ;
            endcase
            barrel_d = barrel_d & ~kill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            cnt_q     <= CNT_LAST;
            dir_q     <= '0;
            barrel_q  <= '0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            busy_q    <= 1'b0;
            spawned_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            barrel_q  <= barrel_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            busy_q    <= busy_d;
            spawned_q <= spawned_d;
        end
    end

    assign barrel  = barrel_q;
    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign busy    = busy_q;
    assign spawned = spawned_q;

endmodule
